slc3_input_conditioner: RTL and testbench

Front-end conditioner between the board's raw push-buttons/switches and the SLC-3 core top level. It synchronises the active-low Run and Continue keys and the 10 slide switches, debounces them, and produces clean levels plus one-cycle event pulses. The core consumes these pulses for reset/start and pause-resume, and samples SW through the memory-mapped switch register.

---
 rtl/slc3_io_pkg.sv | 17 +
 rtl/debounce_channel.sv | 112 +++++++++++
 rtl/slc3_input_conditioner.sv | 80 ++++++++
 tb/tb_slc3_input_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_io_pkg.sv
// Shared types and constants for the SLC-3 board input conditioner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   db_state_t  - per-channel debounce FSM state
//   SYNC_STAGES - depth of the metastability synchroniser on every raw input
package slc3_io_pkg;

  typedef enum logic {
    ST_STABLE,
    ST_CHANGING
  } db_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/debounce_channel.sv
// Synchronise and debounce one WIDTH-bit raw input group into a clean level plus change pulse.
// Latency: stable/change rise SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge sampling a new level.
// Backpressure: none; the change pulse is one cycle wide and is not held for a consumer.
//
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset (chain, stable and candidate return to RESET_VAL)
//   din    - raw asynchronous input
//   stable - debounced value
//   change - one-cycle pulse in the cycle stable takes a new value
module debounce_channel
  import slc3_io_pkg::*;
#(
  parameter int              WIDTH           = 1,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] stable,
  output logic             change
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  synced;

  db_state_t        state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             change_q, change_d;

  // Stage 0 takes the raw pin; the oldest stage feeds the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_STABLE;
      cand_q   <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
      change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      change_q <= change_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    change_d = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (synced != stable_q) begin
          cand_d  = synced;
          cnt_d   = CNT_ONE;
          state_d = ST_CHANGING;
        end
      end
      ST_CHANGING: begin
        if (synced == stable_q) begin
          // Bounced back to the accepted value: drop the candidate silently.
          cnt_d   = '0;
          state_d = ST_STABLE;
        end else if (synced == cand_q) begin
          // The matching sample that finds the count already at the limit is the
          // accepting one, so the pulse lands SYNC_STAGES+DEBOUNCE_CYCLES edges
          // after the raw change is first sampled.
          if (cnt_q >= CNT_MAX) begin
            stable_d = cand_q;
            change_d = 1'b1;
            cnt_d    = '0;
            state_d  = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          // Multi-bit input moved to a third value: restart on the new candidate.
          cand_d = synced;
          cnt_d  = CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign stable = stable_q;
  assign change = change_q;

endmodule

// File: rtl/slc3_input_conditioner.sv
// Board key/switch front end for the SLC-3 core: clean levels and one-cycle press/release/change pulses.
// Latency: outputs react SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge sampling a new raw level.
// Backpressure: none; pulses are single-cycle and must be consumed when they occur.
//
// Ports:
//   Clk, Reset                       - system clock, asynchronous active-high reset
//   Run_n_raw, Continue_n_raw        - raw active-low keys (asynchronous)
//   SW_raw                           - raw slide switches (asynchronous)
//   Run_level, Run_press             - debounced Run pressed level, press pulse
//   Continue_level/_press/_release   - debounced Continue level, press and release pulses
//   SW_stable, SW_change             - debounced switch value, update pulse
module slc3_input_conditioner
  import slc3_io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SW_WIDTH        = 10
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Run_n_raw,
  input  logic                Continue_n_raw,
  input  logic [SW_WIDTH-1:0] SW_raw,
  output logic                Run_level,
  output logic                Run_press,
  output logic                Continue_level,
  output logic                Continue_press,
  output logic                Continue_release,
  output logic [SW_WIDTH-1:0] SW_stable,
  output logic                SW_change
);

  // Key channels debounce the raw active-low pin, so their idle value is 1.
  logic run_n_stable, run_change;
  logic cont_n_stable, cont_change;

  debounce_channel #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_run (
    .clk    (Clk),
    .rst    (Reset),
    .din    (Run_n_raw),
    .stable (run_n_stable),
    .change (run_change)
  );

  debounce_channel #(
    .WIDTH           (1),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_continue (
    .clk    (Clk),
    .rst    (Reset),
    .din    (Continue_n_raw),
    .stable (cont_n_stable),
    .change (cont_change)
  );

  debounce_channel #(
    .WIDTH           (SW_WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       ({SW_WIDTH{1'b0}})
  ) u_sw (
    .clk    (Clk),
    .rst    (Reset),
    .din    (SW_raw),
    .stable (SW_stable),
    .change (SW_change)
  );

  assign Run_level        = ~run_n_stable;
  assign Continue_level   = ~cont_n_stable;

  // The core only acts on Run presses; Run releases are swallowed here.
  assign Run_press        = run_change  &  Run_level;
  assign Continue_press   = cont_change &  Continue_level;
  assign Continue_release = cont_change & ~Continue_level;

endmodule

// File: tb/tb_slc3_input_conditioner.sv
module tb_slc3_input_conditioner;

  localparam int D    = 4;
  localparam int SYNC = 2;
  localparam int LAT  = 1 + SYNC + D;  // edge index of the pulse, first sampling edge = 1

  logic       Clk;
  logic       Reset;
  logic       Run_n_raw;
  logic       Continue_n_raw;
  logic [9:0] SW_raw;
  logic       Run_level, Run_press;
  logic       Continue_level, Continue_press, Continue_release;
  logic [9:0] SW_stable;
  logic       SW_change;

  slc3_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SW_WIDTH        (10)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Run_n_raw        (Run_n_raw),
    .Continue_n_raw   (Continue_n_raw),
    .SW_raw           (SW_raw),
    .Run_level        (Run_level),
    .Run_press        (Run_press),
    .Continue_level   (Continue_level),
    .Continue_press   (Continue_press),
    .Continue_release (Continue_release),
    .SW_stable        (SW_stable),
    .SW_change        (SW_change)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each channel sees its raw input delayed by SYNC edges and
  // accepts a value once it has been seen D+1 times in a row while differing
  // from the accepted value. Channel 0 = Run_n, 1 = Continue_n, 2 = SW.
  logic [9:0] m_pipe   [3][SYNC];
  logic [9:0] m_stable [3];
  logic [9:0] m_cand   [3];
  int         m_run    [3];
  bit         m_pulse  [3];

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      logic [9:0] idle;
      idle = (ch < 2) ? 10'd1 : 10'd0;
      for (int s = 0; s < SYNC; s++) m_pipe[ch][s] = idle;
      m_stable[ch] = idle;
      m_cand[ch]   = idle;
      m_run[ch]    = 0;
      m_pulse[ch]  = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [9:0] raw [3];
    logic [9:0] v;
    raw[0] = {9'd0, Run_n_raw};
    raw[1] = {9'd0, Continue_n_raw};
    raw[2] = SW_raw;
    for (int ch = 0; ch < 3; ch++) begin
      v = m_pipe[ch][SYNC-1];
      m_pulse[ch] = 1'b0;
      if (v == m_stable[ch]) begin
        m_run[ch] = 0;
      end else if (m_run[ch] > 0 && v == m_cand[ch]) begin
        m_run[ch]++;
      end else begin
        m_cand[ch] = v;
        m_run[ch]  = 1;
      end
      if (m_run[ch] == D + 1) begin
        m_stable[ch] = v;
        m_pulse[ch]  = 1'b1;
        m_run[ch]    = 0;
      end
      for (int s = SYNC - 1; s > 0; s--) m_pipe[ch][s] = m_pipe[ch][s-1];
      m_pipe[ch][0] = raw[ch];
    end
  endtask

  task automatic check_outputs();
    chk("run_level",  Run_level,        32'(m_stable[0] == 10'd0));
    chk("run_press",  Run_press,        32'(m_pulse[0] && m_stable[0] == 10'd0));
    chk("cont_level", Continue_level,   32'(m_stable[1] == 10'd0));
    chk("cont_press", Continue_press,   32'(m_pulse[1] && m_stable[1] == 10'd0));
    chk("cont_rel",   Continue_release, 32'(m_pulse[1] && m_stable[1] == 10'd1));
    chk("sw_stable",  SW_stable,        32'(m_stable[2]));
    chk("sw_change",  SW_change,        32'(m_pulse[2]));
  endtask

  // Observed pulse bookkeeping for the directed scenarios.
  int cyc = 0;
  int n_run_press, n_cont_press, n_cont_rel, n_sw_change;
  int at_run_press, at_cont_press, at_sw_change;
  bit saw_sw_020, saw_cont_level;

  task automatic clr();
    n_run_press = 0; n_cont_press = 0; n_cont_rel = 0; n_sw_change = 0;
    at_run_press = -1; at_cont_press = -1; at_sw_change = -1;
    saw_sw_020 = 1'b0; saw_cont_level = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      if (Reset) model_reset();
      else       model_step();
      #1;
      cyc++;
      check_outputs();
      if (Run_press)        begin n_run_press++;  at_run_press  = cyc; end
      if (Continue_press)   begin n_cont_press++; at_cont_press = cyc; end
      if (Continue_release) n_cont_rel++;
      if (SW_change)        begin n_sw_change++;  at_sw_change  = cyc; end
      if (SW_stable == 10'h020) saw_sw_020 = 1'b1;
      if (Continue_level)       saw_cont_level = 1'b1;
    end
  endtask

  task automatic set_reset(input logic r);
    Reset = r;
    if (r) begin
      model_reset();
      #1;
      check_outputs();
    end
  endtask

  int mark;

  initial begin
    Run_n_raw      = 1'b1;
    Continue_n_raw = 1'b1;
    SW_raw         = 10'h00B;
    Reset          = 1'b1;
    model_reset();
    clr();
    #2;
    // Reset state
    chk("rst_run_level",  Run_level,      0);
    chk("rst_cont_level", Continue_level, 0);
    chk("rst_sw_stable",  SW_stable,      0);
    chk("rst_pulses", {Run_press, Continue_press, Continue_release, SW_change}, 0);
    tick(3);

    // 1: switch value present at reset release is picked up once
    Reset = 1'b0; clr(); mark = cyc;
    tick(12);
    chk("init_sw_val",   SW_stable, 10'h00B);
    chk("init_sw_count", n_sw_change, 1);
    chk("init_sw_edge",  at_sw_change - mark, LAT);

    // 2: clean Run press then release
    Run_n_raw = 1'b0; clr(); mark = cyc;
    tick(12);
    chk("run_press_count", n_run_press, 1);
    chk("run_press_edge",  at_run_press - mark, LAT);
    chk("run_level_held",  Run_level, 1);
    Run_n_raw = 1'b1; clr();
    tick(12);
    chk("run_release_nopulse", n_run_press, 0);
    chk("run_release_level",   Run_level, 0);

    // 3: Continue bounce never reaches acceptance
    clr();
    Continue_n_raw = 1'b0; tick(2);
    Continue_n_raw = 1'b1; tick(1);
    Continue_n_raw = 1'b0; tick(2);
    Continue_n_raw = 1'b1; tick(12);
    chk("bounce_press",   n_cont_press, 0);
    chk("bounce_release", n_cont_rel, 0);
    chk("bounce_level",   saw_cont_level, 0);

    // 4: switch moves to a second value before the first is accepted
    clr();
    SW_raw = 10'h020; tick(3);
    SW_raw = 10'h145; mark = cyc;
    tick(12);
    chk("sw_skip_020",   saw_sw_020, 0);
    chk("sw_new_val",    SW_stable, 10'h145);
    chk("sw_new_count",  n_sw_change, 1);
    chk("sw_new_edge",   at_sw_change - mark, LAT);

    // 5: simultaneous presses, then Continue released alone
    clr();
    Run_n_raw = 1'b0; Continue_n_raw = 1'b0; mark = cyc;
    tick(12);
    chk("simul_run_edge",  at_run_press - mark, LAT);
    chk("simul_cont_edge", at_cont_press - mark, LAT);
    clr();
    Continue_n_raw = 1'b1;
    tick(12);
    chk("simul_cont_rel",   n_cont_rel, 1);
    chk("simul_run_level",  Run_level, 1);
    chk("simul_run_quiet",  n_run_press, 0);
    Run_n_raw = 1'b1; tick(12);

    // 6: reset in the middle of a Continue debounce, key held through release
    clr();
    Continue_n_raw = 1'b0;
    tick(4);
    set_reset(1'b1);
    tick(6);
    chk("midrst_press", n_cont_press, 0);
    chk("midrst_level", Continue_level, 0);
    Reset = 1'b0; clr(); mark = cyc;
    tick(12);
    chk("rstheld_count", n_cont_press, 1);
    chk("rstheld_edge",  at_cont_press - mark, LAT);
    Continue_n_raw = 1'b1; tick(12);

    // Random phase: bouncy keys, wandering switches, occasional reset
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 3) == 0) Run_n_raw = ~Run_n_raw;
      if ($urandom_range(0, 3) == 0) Continue_n_raw = ~Continue_n_raw;
      case ($urandom_range(0, 3))
        0: SW_raw = 10'($urandom);
        1: SW_raw = SW_raw ^ (10'd1 << $urandom_range(0, 9));
        default: ;
      endcase
      if ($urandom_range(0, 39) == 0) begin
        set_reset(1'b1);
        tick($urandom_range(1, 3));
        Reset = 1'b0;
      end
      tick($urandom_range(1, 9));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
